hs32_lsu: RTL and testbench
===========================

# hs32_lsu

Parametrised load/store unit for the HS32 core: it takes the memory-access path out of the execute unit's fixed two-state read/write sequence and puts it behind a small command queue. It adds configurable data/address width, byte/half/word accesses with sign or zero extension, byte-lane selects, and misalignment faults. It sits between the execute unit and the memory arbiter, using the same `reqm`/`rdym` hold-until-ready handshake the arbiter already speaks.

## Interface
- `DW`, 32: data width; multiple of 8, ≥32.
- `AW`, 32: address width.
- `DEPTH`, 2: command queue entries; power of two, ≥1.
- `ALIGN_FAULT`, 1: 1 = misaligned access faults; 0 = address silently truncated to natural alignment.
- `clk` in 1: clock.
- `reset` in 1: reset. One clock; reset is asynchronous and active-low.
- `req` in 1: command valid; accepted on a clock edge where `req && rdy`.
- `rdy` out 1: queue not full (combinational from occupancy).
- `rw` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word; 11 is reserved and treated as word.
- `sext` in 1: sign-extend load result.
- `addr` in AW: byte address.
- `wdata` in DW: store data, right-aligned.
- `tag` in 4: destination register number, returned with the result.
- `flush` in 1: discard queued commands that have not been issued.
- `done` out 1: one-cycle completion pulse.
- `rdata` out DW: extended load data; 0 for stores.
- `tag_out` out 4: tag of the completed command.
- `fault` out 1: qualifies `done`; the access was misaligned and not performed.
- `addr_m` out AW: aligned memory address (low log2(DW/8) bits zero).
- `dtwm` out DW: store data, replicated to every lane.
- `dtrm` in DW: memory read data.
- `bsel` out DW/8: byte-lane enables.
- `reqm` out 1: memory request.
- `rdym` in 1: memory ready.
- `rw_mem` out 1: 1 = write.

## Operation
- Reset values: `reqm`, `rw_mem`, `done`, `fault` = 0; `rdata`, `tag_out`, `addr_m`, `dtwm`, `bsel` = 0. The queue is empty and the FSM is in IDLE.
- Queue: FIFO of {rw, size, sext, addr, wdata, tag}.
  - Push on `req && rdy`.
  - Pop only in IDLE when the queue is not empty.
- FSM has two states, IDLE and REQ.
- IDLE with a non-empty queue pops the head:
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0) and `ALIGN_FAULT=1`: set `done=1`, `fault=1`, `tag_out=tag`, `rdata=0`. Stay in IDLE. No memory request is made.
  - Otherwise: load `addr_m`, `bsel`, `dtwm` and `rw_mem`, set `reqm=1`, go to REQ.
- REQ: `reqm` is held at 1, and `addr_m`/`dtwm`/`bsel`/`rw_mem` are held stable, until an edge with `reqm && rdym`. At that edge:
  - Set `reqm=0`, `done=1`, `tag_out` to the command's tag.
  - Set `rdata` to the extracted lane for loads, 0 for stores.
  - Go to IDLE.
- Lane select: offset o = addr mod (DW/8).
  - Byte: bsel = 1<<o.
  - Half: bsel = 3<<o.
  - Word: bsel = 0xF<<o.
- Load extraction: take `dtrm >> 8*o` and mask to 8/16/32 bits. Bits above that are copied from the top bit when `sext=1`, zero otherwise.
- `flush`: empties the queue at the next edge. An access already in REQ completes and reports `done` normally. A push in the same cycle as `flush` is kept and becomes the only queue entry.
- Push and pop in the same edge are both honoured; occupancy is unchanged.
- `reset` asserted mid-access: `reqm` drops immediately and the access is abandoned. The arbiter must tolerate a request that is withdrawn.

## Timing
- Push at edge E0 → `reqm` high after E1 → with `rdym` high in that cycle, `done` is high for the cycle after E2.
- Minimum load-use latency: 2 cycles from the accepting edge to `done`.
- Throughput: at most one access per 2 cycles. `reqm` is low for at least one cycle between consecutive accesses.
- A faulting command takes 1 cycle (pop edge → `done`/`fault`).
- `rdy` responds combinationally to occupancy. A pop does not raise `rdy` until after the edge.

## Structure
- Constants go in the shared execute-unit constants include, extended with `LSU_SZ_B`/`LSU_SZ_H`/`LSU_SZ_W` and the IDLE/REQ state codes.
- The queue is a separate sub-module, `hs32_fifo` (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, clr). The execute unit and fetch can reuse it.
- Lane select and extraction are combinational functions local to `hs32_lsu`.

## Test plan
- Word load: addr 0x104, `dtrm` 0xDEADBEEF, `rdym` on the first `reqm` cycle → `addr_m`=0x104, `bsel`=0xF, `done` 2 cycles after the push, `rdata`=0xDEADBEEF, tag echoed.
- Byte loads: addr 0x203, `dtrm` 0x80112233. With `sext=1` → `bsel`=0x8, `rdata`=0xFFFFFF80. With `sext=0` → `rdata`=0x00000080.
- Half store: addr 0x302, `wdata` 0x0000ABCD → `rw_mem`=1, `bsel`=0xC, `dtwm`=0xABCDABCD; `reqm` is held for 3 cycles while `rdym` stays low.
- Misaligned word at 0x401 → `done`=`fault`=1 one cycle after the pop, `reqm` never asserts. Repeat with `ALIGN_FAULT=0` → `addr_m`=0x400, access performed.
- Fill the queue (DEPTH=2) while the arbiter stalls → `rdy`=0. Assert `flush` during REQ → the in-flight access completes, the queued access is never issued, `rdy`=1.
- Drop `reset` with `reqm`=1 → `reqm`=0 with no clock edge. After release, the queue is empty and the next push is serviced normally.

Source files
------------

// File: rtl/hs32_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hs32_lsu_pkg
// Desc     : Shared constants and types for the HS32 load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package hs32_lsu_pkg;

  localparam int TAG_W = 4;

  // Access size encoding; 2'b11 is reserved and behaves as a word.
  typedef enum logic [1:0] {
    LSU_SZ_B = 2'b00,
    LSU_SZ_H = 2'b01,
    LSU_SZ_W = 2'b10,
    LSU_SZ_R = 2'b11
  } lsu_size_e;

  // Memory-side sequencer states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } lsu_state_e;

  // Number of bytes touched by an access of the given size.
  function automatic int unsigned size_bytes(input logic [1:0] size);
    case (size)
      LSU_SZ_B: size_bytes = 1;
      LSU_SZ_H: size_bytes = 2;
      default:  size_bytes = 4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/hs32_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : hs32_lsu_if
// Desc     : Command and memory-bus bundle of the HS32 load/store unit.
//            slave  : the LSU's view (commands in, memory request out).
//            master : the surrounding execute unit / arbiter view.
// Revision : 1.0 - initial release
// ============================================================================
interface hs32_lsu_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  // Command side (execute unit)
  logic          req;
  logic          rdy;
  logic          rw;
  logic [1:0]    size;
  logic          sext;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    tag;
  logic          flush;
  logic          done;
  logic [DW-1:0] rdata;
  logic [3:0]    tag_out;
  logic          fault;

  // Memory side (arbiter)
  logic [AW-1:0]   addr_m;
  logic [DW-1:0]   dtwm;
  logic [DW-1:0]   dtrm;
  logic [DW/8-1:0] bsel;
  logic            reqm;
  logic            rdym;
  logic            rw_mem;

  modport slave (
    input  req, rw, size, sext, addr, wdata, tag, flush, dtrm, rdym,
    output rdy, done, rdata, tag_out, fault, addr_m, dtwm, bsel, reqm, rw_mem
  );

  modport master (
    output req, rw, size, sext, addr, wdata, tag, flush, dtrm, rdym,
    input  rdy, done, rdata, tag_out, fault, addr_m, dtwm, bsel, reqm, rw_mem
  );

endinterface
`default_nettype wire

// File: rtl/hs32_lsu_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hs32_fifo
// Desc     : Small synchronous FIFO with clear. A push in the same cycle as
//            clr survives and becomes the only entry. Push while full and
//            pop while empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module hs32_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;
  logic [PW-1:0]    wr_idx;

  // Pointer advance with wrap; works for non-power-of-two depths too.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) next_ptr = '0;
    else                     next_ptr = p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // A clear restarts the ring at slot 0, so a concurrent push lands there.
  assign wr_idx  = clr ? '0 : wr_ptr;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? next_ptr('0) : '0;
      count  <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/hs32_lsu.sv
`default_nettype none
// ============================================================================
// Module   : hs32_lsu
// Desc     : HS32 load/store unit. Queues execute-unit commands and replays
//            them one at a time on the reqm/rdym arbiter handshake, with
//            byte/half/word lane selection, load extension and optional
//            misalignment faults.
// Revision : 1.0 - initial release
// ============================================================================
module hs32_lsu
  import hs32_lsu_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 2,
  parameter int ALIGN_FAULT = 1
) (
  input  logic      clk,
  input  logic      reset,
  hs32_lsu_if.slave bus
);

  localparam int NB    = DW / 8;
  localparam int OW    = $clog2(NB);
  localparam int CMD_W = 1 + 2 + 1 + AW + DW + TAG_W;

  typedef struct packed {
    logic             rw;
    logic [1:0]       size;
    logic             sext;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdata;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  // --------------------------------------------------------------------------
  // Lane helpers
  // --------------------------------------------------------------------------

  // Half needs bit 0 clear, word (and reserved) needs bits 1:0 clear.
  function automatic logic misaligned(input logic [1:0] size, input logic [AW-1:0] a);
    case (size)
      LSU_SZ_B: misaligned = 1'b0;
      LSU_SZ_H: misaligned = a[0];
      default:  misaligned = |a[1:0];
    endcase
  endfunction

  // Truncate to natural alignment; identity for already-aligned addresses.
  function automatic logic [AW-1:0] natural_addr(input logic [1:0] size, input logic [AW-1:0] a);
    case (size)
      LSU_SZ_B: natural_addr = a;
      LSU_SZ_H: natural_addr = {a[AW-1:1], 1'b0};
      default:  natural_addr = {a[AW-1:2], 2'b00};
    endcase
  endfunction

  // Byte-lane enables for an access of the given size at lane offset off.
  function automatic logic [NB-1:0] lane_sel(input logic [1:0] size, input logic [OW-1:0] off);
    logic [NB-1:0] base;
    base = '0;
    case (size)
      LSU_SZ_B: base[0]   = 1'b1;
      LSU_SZ_H: base[1:0] = 2'b11;
      default:  base[3:0] = 4'hF;
    endcase
    lane_sel = base << off;
  endfunction

  // Replicate the right-aligned store datum across every lane of the bus.
  function automatic logic [DW-1:0] lane_rep(input logic [1:0] size, input logic [DW-1:0] wd);
    int lb;
    lb = 8 * int'(size_bytes(size));
    for (int i = 0; i < DW; i++) lane_rep[i] = wd[i % lb];
  endfunction

  // Shift the addressed lane down and zero/sign extend it to DW bits.
  function automatic logic [DW-1:0] extract(input logic [1:0] size, input logic sx,
                                            input logic [OW-1:0] off, input logic [DW-1:0] d);
    logic [DW-1:0] shifted;
    logic          fill;
    int            bits;
    shifted = d >> {off, 3'b000};
    bits    = 8 * int'(size_bytes(size));
    fill    = sx & shifted[bits-1];
    for (int i = 0; i < DW; i++) extract[i] = (i < bits) ? shifted[i] : fill;
  endfunction

  // --------------------------------------------------------------------------
  // Command queue
  // --------------------------------------------------------------------------
  cmd_t             cmd_in;
  cmd_t             head;
  logic [CMD_W-1:0] head_bits;
  logic             q_full;
  logic             q_empty;
  logic             push;
  logic             pop;

  lsu_state_e       state;

  assign cmd_in  = {bus.rw, bus.size, bus.sext, bus.addr, bus.wdata, bus.tag};
  assign head    = head_bits;
  assign bus.rdy = !q_full;
  assign push    = bus.req && !q_full;
  // If flush coincides with a pop, the popped head is already being issued
  // this edge and proceeds; only the entries behind it are discarded.
  assign pop     = (state == ST_IDLE) && !q_empty;

  hs32_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clr   (bus.flush),
    .din   (cmd_in),
    .dout  (head_bits),
    .full  (q_full),
    .empty (q_empty)
  );

  // --------------------------------------------------------------------------
  // Head decode
  // --------------------------------------------------------------------------
  logic [AW-1:0] eff_addr;
  logic [OW-1:0] eff_off;
  logic          head_bad;

  assign eff_addr = natural_addr(head.size, head.addr);
  assign eff_off  = eff_addr[OW-1:0];
  assign head_bad = (ALIGN_FAULT != 0) && misaligned(head.size, head.addr);

  // --------------------------------------------------------------------------
  // Sequencer and registered outputs
  // --------------------------------------------------------------------------
  logic             reqm_q;
  logic             rw_mem_q;
  logic             done_q;
  logic             fault_q;
  logic [DW-1:0]    rdata_q;
  logic [TAG_W-1:0] tag_out_q;
  logic [AW-1:0]    addr_m_q;
  logic [DW-1:0]    dtwm_q;
  logic [NB-1:0]    bsel_q;
  logic [TAG_W-1:0] cur_tag;
  logic [1:0]       cur_size;
  logic             cur_sext;
  logic [OW-1:0]    cur_off;

  // Two-state issue/complete sequencer; memory outputs hold while in REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      reqm_q    <= 1'b0;
      rw_mem_q  <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      rdata_q   <= '0;
      tag_out_q <= '0;
      addr_m_q  <= '0;
      dtwm_q    <= '0;
      bsel_q    <= '0;
      cur_tag   <= '0;
      cur_size  <= '0;
      cur_sext  <= 1'b0;
      cur_off   <= '0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            if (head_bad) begin
              // Rejected without touching memory; completes this edge.
              done_q    <= 1'b1;
              fault_q   <= 1'b1;
              tag_out_q <= head.tag;
              rdata_q   <= '0;
            end else begin
              addr_m_q <= {eff_addr[AW-1:OW], {OW{1'b0}}};
              bsel_q   <= lane_sel(head.size, eff_off);
              dtwm_q   <= lane_rep(head.size, head.wdata);
              rw_mem_q <= head.rw;
              reqm_q   <= 1'b1;
              cur_tag  <= head.tag;
              cur_size <= head.size;
              cur_sext <= head.sext;
              cur_off  <= eff_off;
              state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus.rdym) begin
            reqm_q    <= 1'b0;
            rw_mem_q  <= 1'b0;
            done_q    <= 1'b1;
            tag_out_q <= cur_tag;
            rdata_q   <= rw_mem_q ? '0 : extract(cur_size, cur_sext, cur_off, bus.dtrm);
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.reqm    = reqm_q;
  assign bus.rw_mem  = rw_mem_q;
  assign bus.done    = done_q;
  assign bus.fault   = fault_q;
  assign bus.rdata   = rdata_q;
  assign bus.tag_out = tag_out_q;
  assign bus.addr_m  = addr_m_q;
  assign bus.dtwm    = dtwm_q;
  assign bus.bsel    = bsel_q;

endmodule
`default_nettype wire

// File: tb/tb_hs32_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs32_lsu
// Desc     : Self-checking bench for hs32_lsu (one faulting and one
//            truncating instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hs32_lsu;

  localparam int DW = 32;
  localparam int AW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hs32_lsu_if #(.DW(DW), .AW(AW)) bus0 ();
  hs32_lsu_if #(.DW(DW), .AW(AW)) bus1 ();

  hs32_lsu #(.DW(DW), .AW(AW), .DEPTH(2), .ALIGN_FAULT(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  hs32_lsu #(.DW(DW), .AW(AW), .DEPTH(2), .ALIGN_FAULT(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  tag;
  } tcmd_t;

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic longint unsigned m_n(input logic [1:0] s);
    return (s == 2'd0) ? 64'd1 : (s == 2'd1) ? 64'd2 : 64'd4;
  endfunction

  function automatic logic m_fault(input logic [1:0] s, input logic [31:0] a);
    return (longint'(a) % m_n(s)) != 0;
  endfunction

  function automatic longint unsigned m_eff(input logic [1:0] s, input logic [31:0] a);
    longint unsigned av = longint'(a);
    return av - (av % m_n(s));
  endfunction

  function automatic logic [31:0] m_addr(input logic [1:0] s, input logic [31:0] a);
    longint unsigned e = m_eff(s, a);
    return 32'(e - (e % 4));
  endfunction

  function automatic logic [3:0] m_bsel(input logic [1:0] s, input logic [31:0] a);
    longint unsigned lanes = (64'd1 << m_n(s)) - 1;
    return 4'(lanes << (m_eff(s, a) % 4));
  endfunction

  function automatic logic [31:0] m_dtwm(input logic [1:0] s, input logic [31:0] w);
    longint unsigned n = m_n(s);
    longint unsigned v = longint'(w) & ((64'd1 << (8 * n)) - 1);
    if (n == 1) return 32'(v * 64'h0101_0101);
    if (n == 2) return 32'(v * 64'h0001_0001);
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] s, input logic sx,
                                          input logic [31:0] a, input logic [31:0] d);
    longint unsigned n    = m_n(s);
    longint unsigned mask = (64'd1 << (8 * n)) - 1;
    longint unsigned v    = (longint'(d) >> (8 * (m_eff(s, a) % 4))) & mask;
    if (sx && (((v >> (8 * n - 1)) & 1) == 1)) v = v | (~mask & 64'hFFFF_FFFF);
    return 32'(v);
  endfunction

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic clear_inputs();
    bus0.req = 0; bus0.rw = 0; bus0.size = 0; bus0.sext = 0; bus0.addr = 0;
    bus0.wdata = 0; bus0.tag = 0; bus0.flush = 0; bus0.dtrm = 0; bus0.rdym = 0;
    bus1.req = 0; bus1.rw = 0; bus1.size = 0; bus1.sext = 0; bus1.addr = 0;
    bus1.wdata = 0; bus1.tag = 0; bus1.flush = 0; bus1.dtrm = 0; bus1.rdym = 0;
  endtask

  task automatic set_cmd(input int which, input logic rw, input logic [1:0] size,
                         input logic sext, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] tag);
    if (which == 0) begin
      bus0.req = 1; bus0.rw = rw; bus0.size = size; bus0.sext = sext;
      bus0.addr = addr; bus0.wdata = wdata; bus0.tag = tag;
    end else begin
      bus1.req = 1; bus1.rw = rw; bus1.size = size; bus1.sext = sext;
      bus1.addr = addr; bus1.wdata = wdata; bus1.tag = tag;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus0.reqm, bus0.rw_mem, bus0.done, bus0.fault} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {bus0.reqm, bus0.rw_mem, bus0.done, bus0.fault});
    end
    checks++;
    if ({bus0.rdata, bus0.tag_out, bus0.addr_m, bus0.dtwm, bus0.bsel} !== '0) begin
      failures++;
      $display("FAIL reset_data got rdata=%h tag=%h addr_m=%h dtwm=%h bsel=%h exp=all zero",
               bus0.rdata, bus0.tag_out, bus0.addr_m, bus0.dtwm, bus0.bsel);
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if ({bus0.rdy, bus0.reqm, bus0.done} !== 3'b100) begin
      failures++;
      $display("FAIL reset_idle got rdy/reqm/done=%b exp=100", {bus0.rdy, bus0.reqm, bus0.done});
    end
  endtask

  task automatic test_word_load();
    set_cmd(0, 0, 2'd2, 0, 32'h104, 32'h0, 4'h5);
    @(negedge clk);
    bus0.req = 0;
    checks++;
    if (bus0.reqm !== 1'b0) begin
      failures++; $display("FAIL wl_early_reqm got=%b exp=0", bus0.reqm);
    end
    bus0.rdym = 1; bus0.dtrm = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({bus0.reqm, bus0.rw_mem, bus0.addr_m, bus0.bsel} !== {1'b1, 1'b0, 32'h104, 4'hF}) begin
      failures++;
      $display("FAIL wl_req got reqm=%b rw=%b addr_m=%h bsel=%h exp 1 0 00000104 f",
               bus0.reqm, bus0.rw_mem, bus0.addr_m, bus0.bsel);
    end
    @(negedge clk);
    checks++;
    if ({bus0.done, bus0.fault, bus0.reqm, bus0.rdata, bus0.tag_out} !==
        {1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 4'h5}) begin
      failures++;
      $display("FAIL wl_done got done=%b fault=%b reqm=%b rdata=%h tag=%h exp 1 0 0 deadbeef 5",
               bus0.done, bus0.fault, bus0.reqm, bus0.rdata, bus0.tag_out);
    end
    bus0.rdym = 0;
    @(negedge clk);
  endtask

  task automatic test_byte_load();
    logic [31:0] exp_r;
    logic        seen;
    logic        got;
    bus0.rdym = 1; bus0.dtrm = 32'h80112233;
    for (int s = 1; s >= 0; s--) begin
      exp_r = (s == 1) ? 32'hFFFFFF80 : 32'h00000080;
      set_cmd(0, 0, 2'd0, s[0], 32'h203, 32'h0, 4'(6 + s));
      @(negedge clk);
      bus0.req = 0;
      seen = 0; got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        if (bus0.reqm && !seen) begin
          seen = 1;
          checks++;
          if ({bus0.bsel, bus0.addr_m} !== {4'h8, 32'h200}) begin
            failures++;
            $display("FAIL bl_bsel sext=%0d got bsel=%h addr_m=%h exp 8 00000200", s, bus0.bsel, bus0.addr_m);
          end
        end
        if (bus0.done) got = 1;
      end
      checks++;
      if ({got, bus0.rdata, bus0.tag_out} !== {1'b1, exp_r, 4'(6 + s)}) begin
        failures++;
        $display("FAIL bl_rdata sext=%0d got done=%b rdata=%h tag=%h exp 1 %h %h",
                 s, got, bus0.rdata, bus0.tag_out, exp_r, 4'(6 + s));
      end
      @(negedge clk);
    end
    bus0.rdym = 0;
  endtask

  task automatic test_half_store();
    bus0.rdym = 0;
    set_cmd(0, 1, 2'd1, 0, 32'h302, 32'h0000ABCD, 4'h9);
    @(negedge clk);
    bus0.req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus0.reqm, bus0.rw_mem, bus0.done, bus0.bsel, bus0.dtwm, bus0.addr_m} !==
          {1'b1, 1'b1, 1'b0, 4'hC, 32'hABCDABCD, 32'h300}) begin
        failures++;
        $display("FAIL hs_hold cyc=%0d got reqm=%b rw=%b done=%b bsel=%h dtwm=%h addr_m=%h exp 1 1 0 c abcdabcd 00000300",
                 k, bus0.reqm, bus0.rw_mem, bus0.done, bus0.bsel, bus0.dtwm, bus0.addr_m);
      end
    end
    bus0.rdym = 1; bus0.dtrm = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if ({bus0.done, bus0.reqm, bus0.rdata, bus0.tag_out} !== {1'b1, 1'b0, 32'h0, 4'h9}) begin
      failures++;
      $display("FAIL hs_done got done=%b reqm=%b rdata=%h tag=%h exp 1 0 00000000 9",
               bus0.done, bus0.reqm, bus0.rdata, bus0.tag_out);
    end
    bus0.rdym = 0;
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    logic any_req;
    // Faulting instance
    bus0.rdym = 1; bus0.dtrm = 32'h55555555;
    set_cmd(0, 0, 2'd2, 0, 32'h401, 32'h0, 4'h3);
    @(negedge clk);
    bus0.req = 0;
    any_req = bus0.reqm;
    checks++;
    if (bus0.done !== 1'b0) begin
      failures++; $display("FAIL ma_early_done got=%b exp=0", bus0.done);
    end
    @(negedge clk);
    any_req |= bus0.reqm;
    checks++;
    if ({bus0.done, bus0.fault, bus0.tag_out, bus0.rdata} !== {1'b1, 1'b1, 4'h3, 32'h0}) begin
      failures++;
      $display("FAIL ma_fault got done=%b fault=%b tag=%h rdata=%h exp 1 1 3 00000000",
               bus0.done, bus0.fault, bus0.tag_out, bus0.rdata);
    end
    @(negedge clk);
    any_req |= bus0.reqm;
    checks++;
    if ({any_req, bus0.done} !== 2'b00) begin
      failures++; $display("FAIL ma_noreq got reqm_seen=%b done=%b exp 0 0", any_req, bus0.done);
    end
    bus0.rdym = 0;
    // Truncating instance
    bus1.rdym = 1; bus1.dtrm = 32'h12345678;
    set_cmd(1, 0, 2'd2, 0, 32'h401, 32'h0, 4'h4);
    @(negedge clk);
    bus1.req = 0;
    @(negedge clk);
    checks++;
    if ({bus1.reqm, bus1.addr_m, bus1.bsel} !== {1'b1, 32'h400, 4'hF}) begin
      failures++;
      $display("FAIL tr_req got reqm=%b addr_m=%h bsel=%h exp 1 00000400 f", bus1.reqm, bus1.addr_m, bus1.bsel);
    end
    @(negedge clk);
    checks++;
    if ({bus1.done, bus1.fault, bus1.rdata, bus1.tag_out} !== {1'b1, 1'b0, 32'h12345678, 4'h4}) begin
      failures++;
      $display("FAIL tr_done got done=%b fault=%b rdata=%h tag=%h exp 1 0 12345678 4",
               bus1.done, bus1.fault, bus1.rdata, bus1.tag_out);
    end
    bus1.rdym = 0;
    @(negedge clk);
  endtask

  task automatic test_fill_flush();
    logic extra;
    bus0.rdym = 0;
    set_cmd(0, 0, 2'd2, 0, 32'h10, 32'h0, 4'h1);
    @(negedge clk);
    set_cmd(0, 0, 2'd2, 0, 32'h14, 32'h0, 4'h2);
    @(negedge clk);
    set_cmd(0, 0, 2'd2, 0, 32'h18, 32'h0, 4'h3);
    @(negedge clk);
    bus0.req = 0;
    checks++;
    if ({bus0.rdy, bus0.reqm, bus0.addr_m} !== {1'b0, 1'b1, 32'h10}) begin
      failures++;
      $display("FAIL ff_full got rdy=%b reqm=%b addr_m=%h exp 0 1 00000010", bus0.rdy, bus0.reqm, bus0.addr_m);
    end
    bus0.flush = 1;
    @(negedge clk);
    bus0.flush = 0;
    checks++;
    if ({bus0.rdy, bus0.reqm, bus0.addr_m} !== {1'b1, 1'b1, 32'h10}) begin
      failures++;
      $display("FAIL ff_flushed got rdy=%b reqm=%b addr_m=%h exp 1 1 00000010", bus0.rdy, bus0.reqm, bus0.addr_m);
    end
    bus0.rdym = 1; bus0.dtrm = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if ({bus0.done, bus0.tag_out, bus0.rdata} !== {1'b1, 4'h1, 32'hCAFEF00D}) begin
      failures++;
      $display("FAIL ff_inflight got done=%b tag=%h rdata=%h exp 1 1 cafef00d", bus0.done, bus0.tag_out, bus0.rdata);
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      extra |= bus0.reqm | bus0.done;
    end
    checks++;
    if (extra !== 1'b0) begin
      failures++; $display("FAIL ff_discard got activity=%b exp=0", extra);
    end
    bus0.rdym = 0;
  endtask

  task automatic test_reset_mid();
    logic extra;
    bus0.rdym = 0;
    set_cmd(0, 0, 2'd2, 0, 32'h20, 32'h0, 4'h7);
    @(negedge clk);
    set_cmd(0, 0, 2'd2, 0, 32'h24, 32'h0, 4'h8);
    @(negedge clk);
    bus0.req = 0;
    checks++;
    if (bus0.reqm !== 1'b1) begin
      failures++; $display("FAIL rm_pre got reqm=%b exp=1", bus0.reqm);
    end
    #2 reset = 0;
    #1;
    checks++;
    if ({bus0.reqm, bus0.rdy, bus0.bsel} !== {1'b0, 1'b1, 4'h0}) begin
      failures++;
      $display("FAIL rm_async got reqm=%b rdy=%b bsel=%h exp 0 1 0", bus0.reqm, bus0.rdy, bus0.bsel);
    end
    @(negedge clk);
    reset = 1;
    bus0.rdym = 1; bus0.dtrm = 32'h0BADF00D;
    set_cmd(0, 0, 2'd2, 0, 32'h28, 32'h0, 4'hA);
    @(negedge clk);
    bus0.req = 0;
    @(negedge clk);
    checks++;
    if ({bus0.reqm, bus0.addr_m} !== {1'b1, 32'h28}) begin
      failures++; $display("FAIL rm_req got reqm=%b addr_m=%h exp 1 00000028", bus0.reqm, bus0.addr_m);
    end
    @(negedge clk);
    checks++;
    if ({bus0.done, bus0.tag_out, bus0.rdata} !== {1'b1, 4'hA, 32'h0BADF00D}) begin
      failures++;
      $display("FAIL rm_done got done=%b tag=%h rdata=%h exp 1 a 0badf00d", bus0.done, bus0.tag_out, bus0.rdata);
    end
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      extra |= bus0.reqm | bus0.done;
    end
    checks++;
    if (extra !== 1'b0) begin
      failures++; $display("FAIL rm_queue_empty got activity=%b exp=0", extra);
    end
    bus0.rdym = 0;
  endtask

  task automatic test_random();
    tcmd_t       c;
    logic [31:0] cap_d;
    logic [31:0] er;
    logic        ef;
    logic        got;
    logic        seen;
    logic        mem_ok;
    int          nmax = 300;
    for (int n = 0; n < nmax; n++) begin
      c.rw    = 1'($urandom);
      c.size  = 2'($urandom_range(0, 2));
      c.sext  = 1'($urandom);
      c.addr  = $urandom;
      c.wdata = $urandom;
      c.tag   = 4'($urandom);
      bus0.rdym = 0;
      set_cmd(0, c.rw, c.size, c.sext, c.addr, c.wdata, c.tag);
      @(negedge clk);
      bus0.req = 0;
      ef     = m_fault(c.size, c.addr);
      got    = 0;
      seen   = 0;
      mem_ok = 1;
      cap_d  = '0;
      for (int cyc = 0; cyc < 50 && !got; cyc++) begin
        bus0.rdym = 1'($urandom);
        bus0.dtrm = $urandom;
        cap_d     = bus0.dtrm;
        if (bus0.reqm) begin
          seen = 1;
          if ({bus0.rw_mem, bus0.addr_m, bus0.bsel} !==
              {c.rw, m_addr(c.size, c.addr), m_bsel(c.size, c.addr)})
            mem_ok = 0;
          if (c.rw && (bus0.dtwm !== m_dtwm(c.size, c.wdata)))
            mem_ok = 0;
        end
        @(negedge clk);
        if (bus0.done) got = 1;
      end
      er = (ef || c.rw) ? 32'h0 : m_rdata(c.size, c.sext, c.addr, cap_d);
      checks++;
      if ({got, bus0.fault, bus0.rdata, bus0.tag_out, mem_ok, seen} !==
          {1'b1, ef, er, c.tag, 1'b1, !ef}) begin
        failures++;
        $display("FAIL rnd n=%0d rw=%b size=%0d sext=%b addr=%h got done=%b fault=%b rdata=%h tag=%h mem_ok=%b req_seen=%b exp 1 %b %h %h 1 %b",
                 n, c.rw, c.size, c.sext, c.addr, got, bus0.fault, bus0.rdata, bus0.tag_out,
                 mem_ok, seen, ef, er, c.tag, !ef);
      end
      bus0.rdym = 0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_fill_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
